wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master, one-slave Wishbone arbiter that shares the single memory-side bus between the CPU instruction fetch port (ibus, read-only) and data port (dbus). It sits between the CPU and the address-decoding mux. It grants one master at a time, holds the grant until the slave acknowledges, and alternates priority round-robin. A watchdog terminates transactions the slave never acknowledges.

## Interface
- TIMEOUT, 255: cycles in BUSY without slave ack before forced termination; 0 disables the watchdog.
- TW, 8: timeout counter width; TIMEOUT must fit in TW bits.
- i_clk  in  1  system clock.
- i_rst  in  1  reset. Synchronous and active-high, sampled on the rising edge of i_clk.
- i_wb_ibus_adr  in  32  instruction fetch address.
- i_wb_ibus_cyc  in  1  instruction fetch request.
- o_wb_ibus_rdt  out  32  read data to ibus.
- o_wb_ibus_ack  out  1  ibus transfer complete.
- i_wb_dbus_adr  in  32  data address.
- i_wb_dbus_dat  in  32  write data.
- i_wb_dbus_sel  in  4  byte lanes.
- i_wb_dbus_we  in  1  write enable.
- i_wb_dbus_cyc  in  1  data request.
- o_wb_dbus_rdt  out  32  read data to dbus.
- o_wb_dbus_ack  out  1  dbus transfer complete.
- o_wb_adr, o_wb_dat  out  32  slave address and write data.
- o_wb_sel  out  4  slave byte lanes.
- o_wb_we, o_wb_cyc  out  1  slave write enable and cycle.
- i_wb_rdt  in  32  slave read data.
- i_wb_ack  in  1  slave ack.
- o_timeout  out  1  one-cycle pulse on watchdog termination.

## Operation
- States: IDLE, BUSY. Register `owner` (0 = ibus, 1 = dbus). Register `last` holds the most recently granted master.
- IDLE: o_wb_cyc = 0, both acks = 0.
  - One request: latch that master into owner, go to BUSY.
  - Both requests: grant the master that is not `last`.
  - No request: stay in IDLE.
- BUSY: slave outputs follow the owner combinationally.
  - ibus owner: adr = ibus adr, dat = 0, sel = 4'hf, we = 0.
  - o_wb_cyc = owner's cyc.
- BUSY, i_wb_ack high: owner ack = 1 in the same cycle; last <= owner; go to IDLE.
- BUSY, owner cyc drops without ack (abort): go to IDLE. No ack is issued and `last` is not updated.
- Watchdog: counter clears on entry to BUSY and increments each BUSY cycle without ack. When the count equals TIMEOUT-1:
  - owner ack = 1 with rdt forced to 0;
  - o_wb_cyc = 0 in that cycle;
  - o_timeout = 1;
  - last <= owner; go to IDLE.
  - A slave ack in that same cycle takes precedence: normal completion, no timeout pulse.
- o_wb_ibus_rdt and o_wb_dbus_rdt = i_wb_rdt, except 0 during a timeout ack. Masters qualify rdt with their own ack.
- A slave ack while in IDLE is ignored.
- The non-owner's ack is never asserted.

## Timing
- Reset (edge with i_rst = 1): state = IDLE, last = dbus (so ibus wins the first tie), counter = 0. After that edge:
  - o_wb_cyc, both acks and o_timeout = 0;
  - o_wb_we = 0, o_wb_sel = 0, o_wb_adr = 0, o_wb_dat = 0.
- Reset mid-BUSY abandons the transaction with no ack.
- Arbitration latency is one cycle. A request sampled at edge N gives o_wb_cyc high after edge N.
- Ack path is combinational slave-to-master, zero added latency.
- The state returns to IDLE at the edge that samples the ack. The next grant is sampled at the following edge, so back-to-back transfers have one IDLE cycle between them.
- Against a slave with a registered one-cycle ack, a transfer takes 3 cycles from master cyc to the next grant opportunity.
- The master must deassert cyc, or present a new request, the cycle after its ack. The IDLE cycle prevents the old request from being re-granted.

## Structure
- Package wb_arbiter_pkg holds:
  - state encoding: IDLE = 1'b0, BUSY = 1'b1;
  - owner constants: OWN_IBUS = 0, OWN_DBUS = 1.
- Sub-module wb_arb_watchdog is a TW-bit counter. Inputs: clear, enable, parameter TIMEOUT. Output: expire. When TIMEOUT = 0, expire is tied to 0.
- The remaining RTL is a single always block for state, owner, last and counter, plus a combinational output mux.

## Test plan
- Reset, then ibus request only (adr 0x100), slave acks 1 cycle after o_wb_cyc:
  - o_wb_adr = 0x100, we = 0, sel = f;
  - ibus ack in the slave's ack cycle; rdt = slave value 0xDEADBEEF.
- Both requests asserted in the same cycle, repeated 4 times, each master re-requesting after its ack: grants alternate ibus, dbus, ibus, dbus.
- dbus write (adr 0x40000000, dat 0x1, sel 1, we 1):
  - slave sees the exact values;
  - ibus request raised mid-transfer is not granted until after the dbus ack plus the IDLE cycle.
- Slave never acks, TIMEOUT = 4: after 4 BUSY cycles the owner gets ack with rdt 0, o_timeout pulses once, o_wb_cyc is low in that cycle.
- Owner drops cyc in BUSY before ack: return to IDLE, no ack to either master, the next tie still favours the same master as before.
- i_rst asserted during BUSY:
  - o_wb_cyc = 0 after the edge, no ack;
  - the first post-reset tie goes to ibus;
  - a spurious i_wb_ack in IDLE produces no master ack.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// State encoding and bus-owner identifiers.
package wb_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic OWN_IBUS = 1'b0;
  localparam logic OWN_DBUS = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Transaction watchdog for the Wishbone arbiter.
// Counts stalled BUSY cycles; TIMEOUT = 0 disables it.
module wb_arb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TW-1:0] cnt;

  // Stall counter, held at zero outside a transaction
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port
// between the instruction and data buses of the CPU.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_ibus_adr,
  input  logic        i_wb_ibus_cyc,
  output logic [31:0] o_wb_ibus_rdt,
  output logic        o_wb_ibus_ack,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_cyc,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last, last_nxt;
  logic   busy, own_cyc, expire, tmo;

  assign busy    = (state == BUSY);
  assign own_cyc = (owner == OWN_DBUS) ? i_wb_dbus_cyc
                                       : i_wb_ibus_cyc;
  // An abort wins over the watchdog; a slave ack wins over both
  assign tmo     = busy && !i_wb_ack && own_cyc && expire;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wdog (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (!busy),
    .enable (busy && !i_wb_ack),
    .expire (expire)
  );

  // Arbitration state, current owner and round-robin history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      owner <= OWN_IBUS;
      last  <= OWN_DBUS;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Grant decision and slave/master output mux
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    o_wb_adr      = '0;
    o_wb_dat      = '0;
    o_wb_sel      = '0;
    o_wb_we       = 1'b0;
    o_wb_cyc      = 1'b0;
    o_wb_ibus_ack = 1'b0;
    o_wb_dbus_ack = 1'b0;
    o_timeout     = 1'b0;
    o_wb_ibus_rdt = tmo ? '0 : i_wb_rdt;
    o_wb_dbus_rdt = tmo ? '0 : i_wb_rdt;
    unique case (state)
      IDLE: begin
        if (i_wb_ibus_cyc || i_wb_dbus_cyc) begin
          state_nxt = BUSY;
          if (i_wb_ibus_cyc && i_wb_dbus_cyc) begin
            owner_nxt = ~last;
          end else begin
            owner_nxt = i_wb_dbus_cyc;
          end
        end
      end
      BUSY: begin
        if (owner == OWN_DBUS) begin
          o_wb_adr = i_wb_dbus_adr;
          o_wb_dat = i_wb_dbus_dat;
          o_wb_sel = i_wb_dbus_sel;
          o_wb_we  = i_wb_dbus_we;
        end else begin
          o_wb_adr = i_wb_ibus_adr;
          o_wb_sel = 4'hf;
        end
        o_wb_cyc  = own_cyc && !tmo;
        o_timeout = tmo;
        if (i_wb_ack || tmo) begin
          o_wb_ibus_ack = (owner == OWN_IBUS);
          o_wb_dbus_ack = (owner == OWN_DBUS);
          last_nxt      = owner;
          state_nxt     = IDLE;
        end else if (!own_cyc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected grants and
// acks are queued by the stimulus, popped by a monitor.
module tb_wb_arbiter;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } grant_t;

  typedef struct packed {
    logic        ibus;
    logic        dbus;
    logic [31:0] rdt;
    logic        tmo;
    logic        cyc;
    logic [3:0]  lat;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ibus_adr = '0;
  logic        ibus_cyc = 1'b0;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr = '0;
  logic [31:0] dbus_dat = '0;
  logic [3:0]  dbus_sel = '0;
  logic        dbus_we = 1'b0;
  logic        dbus_cyc = 1'b0;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt = 32'hDEADBEEF;
  logic        wb_ack;
  logic        timeout;

  logic slave_en = 1'b1;
  logic s_ack = 1'b0;
  logic spur = 1'b0;

  grant_t gq[$];
  ack_t   aq[$];

  int checks = 0;
  int errors = 0;
  int acks = 0;
  int idle_req = 0;
  int idle_done = 0;
  bit fin_req = 1'b0;
  bit fin_done = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .TIMEOUT (4),
    .TW      (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wb_ibus_adr (ibus_adr),
    .i_wb_ibus_cyc (ibus_cyc),
    .o_wb_ibus_rdt (ibus_rdt),
    .o_wb_ibus_ack (ibus_ack),
    .i_wb_dbus_adr (dbus_adr),
    .i_wb_dbus_dat (dbus_dat),
    .i_wb_dbus_sel (dbus_sel),
    .i_wb_dbus_we  (dbus_we),
    .i_wb_dbus_cyc (dbus_cyc),
    .o_wb_dbus_rdt (dbus_rdt),
    .o_wb_dbus_ack (dbus_ack),
    .o_wb_adr      (wb_adr),
    .o_wb_dat      (wb_dat),
    .o_wb_sel      (wb_sel),
    .o_wb_we       (wb_we),
    .o_wb_cyc      (wb_cyc),
    .i_wb_rdt      (wb_rdt),
    .i_wb_ack      (wb_ack),
    .o_timeout     (timeout)
  );

  // Slave with a registered one-cycle ack
  always @(posedge clk) s_ack <= slave_en && wb_cyc && !s_ack;
  assign wb_ack = s_ack | spur;

  // Monitor: grants, acks, invariants, requested idle checks
  logic prev_cyc = 1'b0;
  logic prev_ack = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    grant_t g, ge;
    ack_t   a, ae;
    logic   anyack;
    anyack = ibus_ack | dbus_ack;
    if (wb_cyc && !prev_cyc) begin
      busy_cnt = 0;
      g = '{wb_adr, wb_dat, wb_sel, wb_we};
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected got %h", g);
      end else begin
        ge = gq.pop_front();
        if (g !== ge) begin
          errors++;
          $display("FAIL grant got %h want %h", g, ge);
        end
      end
    end else begin
      busy_cnt++;
    end
    if (anyack) begin
      acks++;
      a = '{ibus_ack, dbus_ack,
            ibus_ack ? ibus_rdt : dbus_rdt,
            timeout, wb_cyc, busy_cnt[3:0]};
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got %h", a);
      end else begin
        ae = aq.pop_front();
        if (a !== ae) begin
          errors++;
          $display("FAIL ack got %h want %h", a, ae);
        end
      end
    end
    if (prev_ack) begin
      checks++;
      if (wb_cyc !== 1'b0) begin
        errors++;
        $display("FAIL idle_gap cyc got %b want 0", wb_cyc);
      end
    end
    checks++;
    if ((ibus_ack && dbus_ack) || (timeout && !anyack)) begin
      errors++;
      $display("FAIL invariant ib %b db %b tmo %b want no dual/stray",
               ibus_ack, dbus_ack, timeout);
    end
    if (idle_req != idle_done) begin
      idle_done = idle_req;
      checks++;
      if ({wb_cyc, ibus_ack, dbus_ack, timeout, wb_we,
           wb_sel, wb_adr, wb_dat} !== '0) begin
        errors++;
        $display("FAIL idle_out cyc %b ack %b%b tmo %b we %b sel %h adr %h dat %h want all 0",
                 wb_cyc, ibus_ack, dbus_ack, timeout, wb_we,
                 wb_sel, wb_adr, wb_dat);
      end
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      checks++;
      if (gq.size() != 0 || aq.size() != 0) begin
        errors++;
        $display("FAIL queues_left got %0d/%0d want 0/0",
                 gq.size(), aq.size());
      end
    end
    prev_cyc = wb_cyc;
    prev_ack = anyack;
  end

  function automatic grant_t eg(logic [31:0] adr,
                                logic [31:0] dat,
                                logic [3:0] sel,
                                logic we);
    return '{adr, dat, sel, we};
  endfunction

  function automatic ack_t ea(logic dbus, logic tmo);
    ack_t r;
    r.ibus = !dbus;
    r.dbus = dbus;
    r.rdt  = tmo ? 32'h0 : 32'hDEADBEEF;
    r.tmo  = tmo;
    r.cyc  = !tmo;
    r.lat  = tmo ? 4'd3 : 4'd1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n);
    for (int k = 0; k < 200 && acks < n; k++) @(negedge clk);
    if (acks < n) begin
      $display("FAIL wait_ack got %0d want %0d", acks, n);
      $fatal(1, "ack wait expired");
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int na;
    na = 0;
    step();
    step();
    rst = 1'b0;
    idle_req++;
    step();

    // ibus read alone
    gq.push_back(eg(32'h100, 32'h0, 4'hf, 1'b0));
    aq.push_back(ea(1'b0, 1'b0));
    ibus_adr = 32'h100;
    ibus_cyc = 1'b1;
    na += 1;
    wait_acks(na);
    ibus_cyc = 1'b0;
    step();

    // dbus write, ibus raised mid-transfer
    gq.push_back(eg(32'h40000000, 32'h1, 4'h1, 1'b1));
    aq.push_back(ea(1'b1, 1'b0));
    gq.push_back(eg(32'h104, 32'h0, 4'hf, 1'b0));
    aq.push_back(ea(1'b0, 1'b0));
    dbus_adr = 32'h40000000;
    dbus_dat = 32'h1;
    dbus_sel = 4'h1;
    dbus_we  = 1'b1;
    dbus_cyc = 1'b1;
    step();
    ibus_adr = 32'h104;
    ibus_cyc = 1'b1;
    na += 1;
    wait_acks(na);
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;
    na += 1;
    wait_acks(na);
    ibus_cyc = 1'b0;
    step();

    // repeated ties alternate from a fresh reset
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      gq.push_back((i % 2 == 0)
        ? eg(32'h200, 32'h0, 4'hf, 1'b0)
        : eg(32'h300, 32'h55, 4'h3, 1'b0));
      aq.push_back(ea(i % 2 == 1, 1'b0));
    end
    ibus_adr = 32'h200;
    dbus_adr = 32'h300;
    dbus_dat = 32'h55;
    dbus_sel = 4'h3;
    ibus_cyc = 1'b1;
    dbus_cyc = 1'b1;
    na += 4;
    wait_acks(na);
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    step();

    // silent slave: watchdog terminates dbus read
    slave_en = 1'b0;
    gq.push_back(eg(32'h80, 32'h0, 4'hf, 1'b0));
    aq.push_back(ea(1'b1, 1'b1));
    dbus_adr = 32'h80;
    dbus_dat = 32'h0;
    dbus_sel = 4'hf;
    dbus_cyc = 1'b1;
    na += 1;
    wait_acks(na);
    dbus_cyc = 1'b0;
    step();

    // ibus aborts; tie afterwards still goes to ibus
    gq.push_back(eg(32'h500, 32'h0, 4'hf, 1'b0));
    ibus_adr = 32'h500;
    ibus_cyc = 1'b1;
    step();
    step();
    ibus_cyc = 1'b0;
    repeat (3) step();
    slave_en = 1'b1;
    gq.push_back(eg(32'h600, 32'h0, 4'hf, 1'b0));
    aq.push_back(ea(1'b0, 1'b0));
    gq.push_back(eg(32'h700, 32'h22, 4'h2, 1'b1));
    aq.push_back(ea(1'b1, 1'b0));
    ibus_adr = 32'h600;
    dbus_adr = 32'h700;
    dbus_dat = 32'h22;
    dbus_sel = 4'h2;
    dbus_we  = 1'b1;
    ibus_cyc = 1'b1;
    dbus_cyc = 1'b1;
    na += 2;
    wait_acks(na);
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;
    step();

    // ibus wins last, then reset mid dbus transfer
    gq.push_back(eg(32'h800, 32'h0, 4'hf, 1'b0));
    aq.push_back(ea(1'b0, 1'b0));
    ibus_adr = 32'h800;
    ibus_cyc = 1'b1;
    na += 1;
    wait_acks(na);
    ibus_cyc = 1'b0;
    step();
    slave_en = 1'b0;
    gq.push_back(eg(32'h900, 32'h0, 4'hf, 1'b0));
    dbus_adr = 32'h900;
    dbus_dat = 32'h0;
    dbus_sel = 4'hf;
    dbus_cyc = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dbus_cyc = 1'b0;
    idle_req++;
    step();
    slave_en = 1'b1;
    spur = 1'b1;
    idle_req++;
    step();
    spur = 1'b0;
    step();
    gq.push_back(eg(32'hA00, 32'h0, 4'hf, 1'b0));
    aq.push_back(ea(1'b0, 1'b0));
    gq.push_back(eg(32'hB00, 32'h33, 4'h4, 1'b1));
    aq.push_back(ea(1'b1, 1'b0));
    ibus_adr = 32'hA00;
    dbus_adr = 32'hB00;
    dbus_dat = 32'h33;
    dbus_sel = 4'h4;
    dbus_we  = 1'b1;
    ibus_cyc = 1'b1;
    dbus_cyc = 1'b1;
    na += 2;
    wait_acks(na);
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;

    repeat (3) step();
    fin_req = 1'b1;
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
